// File: rtl/int_context_stack_pkg.sv
// Shared types for the interrupt context save/restore block and the execute-stage flag register.
package int_context_stack_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_FL,
        VEC,
        POP_FL,
        POP_LO,
        POP_HI,
        POP_END
    } ctx_state_t;

    // Bit positions inside the 3-bit flag register {carry, negative, zero}
    localparam int FLAG_W     = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

    function automatic logic [15:0] flags_word(input logic [FLAG_W-1:0] f);
        return {13'b0, f};
    endfunction

endpackage

// File: rtl/int_context_stack_sp_reg.sv
// Stack pointer register: reset to SP_INIT, moves by one 3-word frame per push or pop.
module int_context_stack_sp_reg #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(16'h07FF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dec3,
    input  logic              i_inc3,
    output logic [ADDR_W-1:0] o_sp
);

    logic [ADDR_W-1:0] r_sp;

    always_ff @(posedge clk) begin
        if (rst)
            r_sp <= SP_INIT;
        else if (i_dec3)
            r_sp <= r_sp - ADDR_W'(3);
        else if (i_inc3)
            r_sp <= r_sp + ADDR_W'(3);
    end

    assign o_sp = r_sp;

endmodule

// File: rtl/int_context_stack.sv
// Saves PC/flags to the data-memory stack on interrupt entry and restores them on RTI.
// Optional macro STACK_GUARD_EN adds a sticky stack_err output and skips out-of-range frames.
module int_context_stack
    import int_context_stack_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] SP_INIT    = ADDR_W'(16'h07FF),
    parameter logic [31:0]       INT_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic              rti_req,
    input  logic [31:0]       cur_pc,
    input  logic [FLAG_W-1:0] cur_flags,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              busy,
    output logic              int_ack,
    output logic              pc_load,
    output logic [31:0]       new_pc,
    output logic [FLAG_W-1:0] conditions_from_memory_pop,
    output logic              flag_regsel,
    output logic [ADDR_W-1:0] sp_out
`ifdef STACK_GUARD_EN
    ,
    output logic              stack_err
`endif
);

    ctx_state_t        r_state, w_state_nxt;
    logic [31:0]       r_pc;
    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] r_pop_flags;
    logic [FLAG_W-1:0] r_cond;
    logic [15:0]       r_pc_lo;
    logic [ADDR_W-1:0] w_sp;
    logic              w_latch;
    logic              w_sp_dec3;
    logic              w_sp_inc3;
    logic              w_push_bad;
    logic              w_pop_bad;
    logic              w_skip;

    int_context_stack_sp_reg #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk    (clk),
        .rst    (rst),
        .i_dec3 (w_sp_dec3),
        .i_inc3 (w_sp_inc3),
        .o_sp   (w_sp)
    );

    assign sp_out = w_sp;

`ifdef STACK_GUARD_EN
    logic r_skip;
    logic w_err_set;

    // A push needs SP, SP-1, SP-2 without wrapping; a pop needs a full frame above SP.
    assign w_push_bad = (w_sp < ADDR_W'(2));
    assign w_pop_bad  = (w_sp > (SP_INIT - ADDR_W'(3)));
    assign w_err_set  = (r_state == IDLE) &&
                        ((int_req && w_push_bad) || (!int_req && rti_req && w_pop_bad));
    assign w_skip     = r_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            r_skip <= (r_state == IDLE) && !int_req && rti_req && w_pop_bad;
            if (w_err_set)
                stack_err <= 1'b1;
        end
    end
`else
    assign w_push_bad = 1'b0;
    assign w_pop_bad  = 1'b0;
    assign w_skip     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_flags     <= '0;
            r_pop_flags <= '0;
            r_pc_lo     <= '0;
            r_cond      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_pc    <= cur_pc;
                r_flags <= cur_flags;
            end
            // Read data lags mem_re by one cycle, so each capture sits one state later.
            if (r_state == POP_LO)
                r_pop_flags <= mem_rdata[FLAG_W-1:0];
            if (r_state == POP_HI)
                r_pc_lo <= mem_rdata;
            if (r_state == POP_END && !w_skip)
                r_cond <= r_pop_flags;
        end
    end

    assign conditions_from_memory_pop = (r_state == POP_END && !w_skip) ? r_pop_flags : r_cond;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_sp_dec3   = 1'b0;
        w_sp_inc3   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        busy        = 1'b1;
        int_ack     = 1'b0;
        pc_load     = 1'b0;
        new_pc      = '0;
        flag_regsel = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (int_req) begin
                    if (w_push_bad) begin
                        w_state_nxt = VEC;
                    end else begin
                        w_state_nxt = PUSH_HI;
                        w_latch     = 1'b1;
                    end
                end else if (rti_req) begin
                    w_state_nxt = w_pop_bad ? POP_END : POP_FL;
                end
            end
            PUSH_HI: begin
                mem_we      = 1'b1;
                mem_addr    = w_sp;
                mem_wdata   = r_pc[31:16];
                w_state_nxt = PUSH_LO;
            end
            PUSH_LO: begin
                mem_we      = 1'b1;
                mem_addr    = w_sp - ADDR_W'(1);
                mem_wdata   = r_pc[15:0];
                w_state_nxt = PUSH_FL;
            end
            PUSH_FL: begin
                mem_we      = 1'b1;
                mem_addr    = w_sp - ADDR_W'(2);
                mem_wdata   = flags_word(r_flags);
                w_sp_dec3   = 1'b1;
                w_state_nxt = VEC;
            end
            VEC: begin
                pc_load     = 1'b1;
                new_pc      = INT_VECTOR;
                int_ack     = 1'b1;
                w_state_nxt = IDLE;
            end
            POP_FL: begin
                mem_re      = 1'b1;
                mem_addr    = w_sp + ADDR_W'(1);
                w_state_nxt = POP_LO;
            end
            POP_LO: begin
                mem_re      = 1'b1;
                mem_addr    = w_sp + ADDR_W'(2);
                w_state_nxt = POP_HI;
            end
            POP_HI: begin
                mem_re      = 1'b1;
                mem_addr    = w_sp + ADDR_W'(3);
                w_state_nxt = POP_END;
            end
            POP_END: begin
                w_state_nxt = IDLE;
                if (!w_skip) begin
                    pc_load     = 1'b1;
                    new_pc      = {mem_rdata, r_pc_lo};
                    flag_regsel = 1'b1;
                    w_sp_inc3   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_context_stack.sv
// Randomized self-checking bench: a stack-of-frames model predicts every memory access and restore.
module tb_int_context_stack;

    localparam logic [15:0] SP_INIT    = 16'h07FF;
    localparam logic [31:0] INT_VECTOR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, int_req, rti_req;
    logic [31:0] cur_pc;
    logic [2:0]  cur_flags;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr, mem_wdata, sp_out;
    logic        mem_we, mem_re, busy, int_ack, pc_load, flag_regsel;
    logic [31:0] new_pc;
    logic [2:0]  conditions_from_memory_pop;
`ifdef STACK_GUARD_EN
    logic        stack_err;
`endif

    int_context_stack dut (
        .clk                        (clk),
        .rst                        (rst),
        .int_req                    (int_req),
        .rti_req                    (rti_req),
        .cur_pc                     (cur_pc),
        .cur_flags                  (cur_flags),
        .mem_rdata                  (mem_rdata),
        .mem_addr                   (mem_addr),
        .mem_wdata                  (mem_wdata),
        .mem_we                     (mem_we),
        .mem_re                     (mem_re),
        .busy                       (busy),
        .int_ack                    (int_ack),
        .pc_load                    (pc_load),
        .new_pc                     (new_pc),
        .conditions_from_memory_pop (conditions_from_memory_pop),
        .flag_regsel                (flag_regsel),
        .sp_out                     (sp_out)
`ifdef STACK_GUARD_EN
        ,
        .stack_err                  (stack_err)
`endif
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, one-cycle read latency.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Reference model: a LIFO of {pc, flags} frames plus the expected SP and last restored flags.
    logic [34:0] m_stk[$];
    logic [15:0] m_sp;
    logic [2:0]  m_cond;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_sp   = SP_INIT;
        m_cond = 3'b000;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_re"}, mem_re, 0);
        chk({tag, "_pcld"}, pc_load, 0);
        chk({tag, "_frs"}, flag_regsel, 0);
        chk({tag, "_ack"}, int_ack, 0);
        chk({tag, "_sp"}, sp_out, m_sp);
        chk({tag, "_cond"}, conditions_from_memory_pop, m_cond);
    endtask

    task automatic do_int(input logic [31:0] pc, input logic [2:0] fl, input logic with_rti);
        logic [15:0] base, a, d;
        base = m_sp;
        @(negedge clk);
        check_idle("int_pre");
        int_req = 1'b1; rti_req = with_rti; cur_pc = pc; cur_flags = fl;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rti_req = 1'b0;
            cur_pc = $urandom; cur_flags = 3'($urandom);
            a = base - 16'(k);
            d = (k == 0) ? pc[31:16] : (k == 1) ? pc[15:0] : {13'b0, fl};
            chk("push_we", mem_we, 1);
            chk("push_re", mem_re, 0);
            chk("push_busy", busy, 1);
            chk("push_pcld", pc_load, 0);
            chk("push_addr", mem_addr, a);
            chk("push_data", mem_wdata, d);
        end
        @(negedge clk);
        chk("vec_pcld", pc_load, 1);
        chk("vec_pc", new_pc, INT_VECTOR);
        chk("vec_ack", int_ack, 1);
        chk("vec_busy", busy, 1);
        chk("vec_we", mem_we, 0);
        int_req = 1'b0;
        m_stk.push_back({pc, fl});
        m_sp = base - 16'd3;
        @(negedge clk);
        check_idle("int_post");
        chk("mem_hi", mem[base], pc[31:16]);
        chk("mem_lo", mem[base - 16'd1], pc[15:0]);
        chk("mem_fl", mem[base - 16'd2], {13'b0, fl});
    endtask

    task automatic do_rti();
        logic [34:0] fr;
        logic [15:0] base;
        fr   = m_stk.pop_back();
        base = m_sp;
        @(negedge clk);
        check_idle("rti_pre");
        rti_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rti_req = 1'b0;
            chk("pop_re", mem_re, 1);
            chk("pop_we", mem_we, 0);
            chk("pop_busy", busy, 1);
            chk("pop_addr", mem_addr, base + 16'(k));
            chk("pop_pcld", pc_load, 0);
            chk("pop_frs", flag_regsel, 0);
            chk("pop_cond_hold", conditions_from_memory_pop, m_cond);
        end
        @(negedge clk);
        chk("end_pcld", pc_load, 1);
        chk("end_pc", new_pc, fr[34:3]);
        chk("end_frs", flag_regsel, 1);
        chk("end_cond", conditions_from_memory_pop, fr[2:0]);
        chk("end_busy", busy, 1);
        chk("end_re", mem_re, 0);
        m_cond = fr[2:0];
        m_sp   = base + 16'd3;
        @(negedge clk);
        check_idle("rti_post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] base;
        rst = 1'b1; int_req = 1'b0; rti_req = 1'b0; cur_pc = '0; cur_flags = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        chk("reset_newpc", new_pc, 0);

`ifdef STACK_GUARD_EN
        // Pop from an empty stack: one busy cycle, nothing restored.
        @(negedge clk);
        rti_req = 1'b1;
        @(negedge clk);
        rti_req = 1'b0;
        chk("guard_busy", busy, 1);
        chk("guard_re", mem_re, 0);
        chk("guard_pcld", pc_load, 0);
        chk("guard_frs", flag_regsel, 0);
        chk("guard_err", stack_err, 1);
        @(negedge clk);
        check_idle("guard_post");
        chk("guard_err_sticky", stack_err, 1);
`endif

        // Directed frame, then nested pairs.
        do_int(32'h1234_5678, 3'b101, 1'b0);
        do_rti();
        do_int(32'hAAAA_0001, 3'b011, 1'b0);
        do_int(32'h5555_0002, 3'b100, 1'b0);
        do_rti();
        do_rti();
        chk("nested_sp", sp_out, SP_INIT);

        // Simultaneous request: interrupt wins, RTI dropped.
        do_int(32'hCAFE_F00D, 3'b010, 1'b1);
        chk("simul_sp", sp_out, 16'h07FC);
        do_rti();

        // Randomized mix of interrupts and returns.
        for (int i = 0; i < 60; i++) begin
            if (m_stk.size() == 0 || (m_stk.size() < 8 && $urandom_range(0, 1) == 1))
                do_int($urandom, 3'($urandom), 1'($urandom_range(0, 3) == 0));
            else
                do_rti();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        while (m_stk.size() > 0) do_rti();

        // Reset during PUSH_LO aborts the frame.
        do_int(32'h0BAD_0BAD, 3'b001, 1'b0);
        base = m_sp;
        @(negedge clk);
        int_req = 1'b1; cur_pc = 32'h1111_2222; cur_flags = 3'b110;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_addr", mem_addr, base - 16'd1);
        rst = 1'b1; int_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_idle("rst_mid");
        chk("rst_mid_newpc", new_pc, 0);
        do_int(32'h3333_4444, 3'b111, 1'b0);
        do_rti();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
